// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains FRAME_LEN samples per pass from a one-cycle-latency
// FIFO read port into a valid/ready stream, replaying the frame via rewind.
module fifo_frame_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 784,
    parameter int unsigned PASS_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PASS_W-1:0]     num_passes,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_rewind,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_frame_last
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned ENT_W = DATA_WIDTH + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_REWIND = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]        state, state_nx;
    logic [PASS_W-1:0] pass_left, pass_left_nx;
    logic [CNT_W-1:0]  rd_cnt, rd_cnt_nx;
    logic              busy_nx, done_nx, rewind_nx;

    // Output buffer: two skid entries plus the datum currently on fifo_out.
    logic              inflight, inf_last, inf_flast;
    logic [ENT_W-1:0]  buf0, buf1;
    logic [1:0]        occ;

    logic [ENT_W-1:0]  inf_ent, head, second;
    logic [1:0]        cnt, left;
    logic              pop, last_rd;

    // Stream view: oldest buffered entry first, then the in-flight read data.
    assign inf_ent      = {inf_flast, inf_last, fifo_out};
    assign cnt          = occ + {1'b0, inflight};
    assign head         = (occ != 2'd0) ? buf0 : inf_ent;
    assign second       = (occ == 2'd2) ? buf1 : inf_ent;
    assign m_valid      = (cnt != 2'd0);
    assign m_data       = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_last       = m_valid & head[DATA_WIDTH];
    assign m_frame_last = m_valid & head[DATA_WIDTH+1];
    assign pop          = m_valid & m_ready;
    assign left         = cnt - {1'b0, pop};
    assign last_rd      = (rd_cnt == CNT_W'(FRAME_LEN - 1));

    // Read only when the result is guaranteed a buffer slot next cycle.
    assign fifo_rd_en = (state == S_READ) && !abort && !fifo_empty &&
                        (rd_cnt < CNT_W'(FRAME_LEN)) && (left < 2'd2);

    // FSM state and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pass_left      <= '0;
            rd_cnt         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fifo_rd_rewind <= 1'b0;
        end else begin
            state          <= state_nx;
            pass_left      <= pass_left_nx;
            rd_cnt         <= rd_cnt_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            fifo_rd_rewind <= rewind_nx;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nx     = state;
        pass_left_nx = pass_left;
        rd_cnt_nx    = rd_cnt;
        busy_nx      = busy;
        done_nx      = 1'b0;
        rewind_nx    = 1'b0;
        if (fifo_rd_en) begin
            rd_cnt_nx = rd_cnt + CNT_W'(1);
        end
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    state_nx     = S_READ;
                    pass_left_nx = (num_passes == '0) ? PASS_W'(1) : num_passes;
                    rd_cnt_nx    = '0;
                    busy_nx      = 1'b1;
                end
            end
            S_READ: begin
                if (fifo_rd_en && last_rd) begin
                    if (pass_left > PASS_W'(1)) begin
                        state_nx  = S_REWIND;
                        rewind_nx = 1'b1;
                    end else begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_REWIND: begin
                state_nx     = S_READ;
                pass_left_nx = pass_left - PASS_W'(1);
                rd_cnt_nx    = '0;
            end
            S_DRAIN: begin
                if (left == 2'd0) begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx     = S_IDLE;
            pass_left_nx = '0;
            rd_cnt_nx    = '0;
            busy_nx      = 1'b0;
            done_nx      = 1'b0;
            rewind_nx    = 1'b0;
        end
    end

    // Skid buffer: unpopped items move into the entries, new read becomes in-flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            inf_last  <= 1'b0;
            inf_flast <= 1'b0;
            buf0      <= '0;
            buf1      <= '0;
            occ       <= 2'd0;
        end else if (abort) begin
            inflight  <= 1'b0;
            inf_last  <= 1'b0;
            inf_flast <= 1'b0;
            occ       <= 2'd0;
        end else begin
            inflight  <= fifo_rd_en;
            inf_last  <= last_rd;
            inf_flast <= last_rd && (pass_left == PASS_W'(1));
            occ       <= left;
            if (pop) begin
                buf0 <= second;
            end else begin
                buf0 <= head;
                buf1 <= second;
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Testbench for fifo_frame_reader with a small behavioural read-port FIFO model.
module tb_fifo_frame_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned FL = 8;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic [PW-1:0] num_passes = '0;
    logic          busy, done, fifo_rd_en, fifo_rd_rewind, fifo_empty;
    logic          m_valid, m_last, m_frame_last;
    logic [DW-1:0] fifo_out, m_data;

    int vec = 0;
    int errs = 0;
    logic [DW+1:0] exp_q[$];

    // FIFO model controls and state
    logic          fifo_reset = 1'b1;
    logic          trickle = 1'b0;
    logic [3:0]    rd_ptr, fill;
    logic [1:0]    tick;
    logic [DW-1:0] mem [FL];

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .PASS_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes),
        .abort(abort), .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_rewind(fifo_rd_rewind), .fifo_empty(fifo_empty),
        .fifo_out(fifo_out), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .m_frame_last(m_frame_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr >= fill);

    // Read port with one-cycle latency, rewind to frame start, optional slow fill
    always @(posedge clk) begin
        if (fifo_reset) begin
            rd_ptr   <= 4'd0;
            fill     <= trickle ? 4'd0 : 4'd8;
            tick     <= 2'd0;
            fifo_out <= '0;
        end else begin
            if (fifo_rd_rewind) begin
                rd_ptr <= 4'd0;
            end else if (fifo_rd_en && !fifo_empty) begin
                fifo_out <= mem[rd_ptr[2:0]];
                rd_ptr   <= rd_ptr + 4'd1;
            end
            if (trickle) begin
                tick <= (tick == 2'd2) ? 2'd0 : tick + 2'd1;
                if (tick == 2'd2 && fill < 4'd8) fill <= fill + 4'd1;
            end
        end
    end

    task automatic fifo_prep(input bit tr);
        trickle = tr;
        fifo_reset = 1'b1;
        @(posedge clk); #1;
        fifo_reset = 1'b0;
    endtask

    task automatic push_frames(input int eff);
        exp_q.delete();
        for (int p = 0; p < eff; p++)
            for (int i = 0; i < int'(FL); i++)
                exp_q.push_back({(i == 7) && (p == eff - 1), i == 7, DW'(i)});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if ({busy, done, fifo_rd_en, fifo_rd_rewind, m_valid, m_last, m_frame_last} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done, fifo_rd_en, fifo_rd_rewind, m_valid, m_last, m_frame_last});
        end
        vec++;
        if (m_data !== '0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0000", m_data);
        end
        rst_n = 1'b1;
        fifo_reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Exact cycle timing of a single pass with m_ready held high
    task automatic test_single_timing();
        logic [DW+1:0] got, want;
        fifo_prep(1'b0);
        push_frames(1);
        m_ready = 1'b1;
        start = 1'b1;
        num_passes = PW'(1);
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            got = {m_frame_last, m_last, m_data};
            vec++;
            if (m_valid !== 1'((c >= 2) && (c <= 9))) begin
                errs++;
                $display("FAIL single_valid c%0d: got %b want %b", c, m_valid, (c >= 2) && (c <= 9));
            end
            if (m_valid) begin
                vec++;
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                if (got !== want) begin
                    errs++;
                    $display("FAIL single_data c%0d: got %h want %h", c, got, want);
                end
            end
            vec++;
            if (done !== 1'(c == 10) || busy !== 1'((c >= 1) && (c <= 9))) begin
                errs++;
                $display("FAIL single_done_busy c%0d: got %b%b want %b%b", c, done, busy,
                         c == 10, (c >= 1) && (c <= 9));
            end
            if (c == 1) begin
                vec++;
                if (fifo_rd_en !== 1'b1) begin
                    errs++;
                    $display("FAIL single_first_read: got %b want 1", fifo_rd_en);
                end
            end
        end
        m_ready = 1'b0;
    endtask

    // Scoreboarded multi-pass run with random back-pressure and FIFO pacing
    task automatic run_frame(input int passes, input int unsigned rdy_pct, input bit tr, input string nm);
        int eff;
        int rw;
        bit prev_rw, stall, seen_done;
        logic [DW+1:0] got, want, prev_ent;
        eff = (passes == 0) ? 1 : passes;
        rw = 0; prev_rw = 0; stall = 0; seen_done = 0; prev_ent = '0;
        fifo_prep(tr);
        push_frames(eff);
        m_ready = ($urandom_range(99) < rdy_pct);
        start = 1'b1;
        num_passes = PW'(passes);
        for (int c = 0; c < 600 && !seen_done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                m_ready = ($urandom_range(99) < rdy_pct);
            end
            @(negedge clk);
            got = {m_frame_last, m_last, m_data};
            vec++;
            if (fifo_rd_en && fifo_empty) begin
                errs++;
                $display("FAIL %s rd_when_empty c%0d: got rd_en=1 want 0", nm, c);
            end
            if (fifo_rd_rewind) begin
                rw++;
                vec++;
                if (prev_rw) begin
                    errs++;
                    $display("FAIL %s rewind_width c%0d: got 2+ cycles want 1", nm, c);
                end
            end
            prev_rw = fifo_rd_rewind;
            if (stall) begin
                vec++;
                if (!m_valid || got !== prev_ent) begin
                    errs++;
                    $display("FAIL %s stall_hold c%0d: got %b/%h want 1/%h", nm, c, m_valid, got, prev_ent);
                end
            end
            if (m_valid && m_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL %s extra_sample c%0d: got %h want none", nm, c, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errs++;
                        $display("FAIL %s data c%0d: got %h want %h", nm, c, got, want);
                    end
                end
            end
            stall = m_valid && !m_ready;
            prev_ent = got;
            if (done) begin
                seen_done = 1;
                vec++;
                if (busy !== 1'b0 || exp_q.size() != 0) begin
                    errs++;
                    $display("FAIL %s done_state: got busy=%b left=%0d want 0/0", nm, busy, exp_q.size());
                end
            end
        end
        vec++;
        if (!seen_done) begin
            errs++;
            $display("FAIL %s timeout: got no done want done", nm);
        end
        vec++;
        if (rw != eff - 1) begin
            errs++;
            $display("FAIL %s rewinds: got %0d want %0d", nm, rw, eff - 1);
        end
        m_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multi_pass();
        run_frame(3, 100, 1'b0, "multi_pass");
    endtask

    task automatic test_back_pressure();
        run_frame(3, 50, 1'b0, "back_pressure");
    endtask

    task automatic test_slow_fifo();
        run_frame(1, 100, 1'b1, "slow_fifo");
    endtask

    task automatic test_zero_passes();
        run_frame(0, 100, 1'b0, "zero_passes");
    endtask

    task automatic test_abort();
        fifo_prep(1'b0);
        m_ready = 1'b1;
        start = 1'b1;
        num_passes = PW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        vec++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL abort_pre_busy: got %b want 1", busy);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, m_valid, fifo_rd_en} !== 3'b000) begin
            errs++;
            $display("FAIL abort_idle: got %b want 000", {busy, m_valid, fifo_rd_en});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec++;
            if (done !== 1'b0 || fifo_rd_rewind !== 1'b0) begin
                errs++;
                $display("FAIL abort_no_done k%0d: got %b%b want 00", k, done, fifo_rd_rewind);
            end
        end
        @(posedge clk); #1;
        run_frame(2, 100, 1'b0, "after_abort");
    endtask

    task automatic test_async_reset();
        fifo_prep(1'b0);
        m_ready = 1'b1;
        start = 1'b1;
        num_passes = PW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({busy, m_valid, fifo_rd_en} !== 3'b000) begin
            errs++;
            $display("FAIL async_reset: got %b want 000", {busy, m_valid, fifo_rd_en});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        run_frame(2, 100, 1'b0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < int'(FL); i++) mem[i] = DW'(i);
        test_reset();
        test_single_timing();
        test_multi_pass();
        test_back_pressure();
        test_slow_fifo();
        test_zero_passes();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Read-side sequencer for the synchronous BRAM FIFO used in the chirp buffering path. It drains a fixed-length frame from the FIFO's read port, which has one-cycle read latency, and presents it as a valid/ready stream with per-pass and final-pass markers. It can replay the same buffered frame several times using the FIFO's rewind strobe, for example one pass per Doppler/angle processing stage. It sits between the FIFO read port and downstream FFT/accumulate stages and absorbs downstream back-pressure without losing or duplicating samples.

## Interface
- DATA_WIDTH, 16, sample width.
- FRAME_LEN, 784, samples read per pass; must equal the FIFO buffer fill used for rewind.
- PASS_W, 4, width of pass-count input.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a multi-pass read; ignored while busy.
- num_passes  in  PASS_W  passes to perform, sampled on accepted start; 0 treated as 1.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- busy  out  1  high from cycle after accepted start until done cycle (exclusive).
- done  out  1  one-cycle pulse after final sample handshake.
- fifo_rd_en  out  1  FIFO read request; data appears on fifo_out next cycle.
- fifo_rd_rewind  out  1  one-cycle FIFO rewind strobe between passes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en && !fifo_empty.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; transfer when m_valid && m_ready.
- m_last  out  1  high on last sample of each pass.
- m_frame_last  out  1  high on last sample of final pass.

## Operation
- States:
  - IDLE: waits for start.
  - READ: issues reads for the current pass.
  - REWIND: strobes the FIFO rewind.
  - DRAIN: delivers the buffered output.
- Transitions:
  - IDLE -> READ on start; load pass_left = max(num_passes,1), clear sample counter.
  - READ -> REWIND when FRAME_LEN reads have been issued and pass_left > 1.
  - READ -> DRAIN when FRAME_LEN reads have been issued and pass_left == 1.
  - REWIND -> READ after exactly one cycle; decrement pass_left, clear sample counter.
  - DRAIN -> IDLE when the output buffer is empty and no read is in flight; pulse done in that cycle.
- Output buffer: 2-entry skid FIFO, plus one in-flight flag for the read issued last cycle.
- fifo_rd_en = (state==READ) && !fifo_empty && (reads_issued < FRAME_LEN) && (occ + inflight - pop < 2), where pop = m_valid && m_ready. It is never asserted when fifo_empty.
- Captured data carries tags: last is set when the read index == FRAME_LEN-1; frame_last is set when additionally pass_left == 1.
- Sample counter is clogb2(FRAME_LEN) bits and saturates at FRAME_LEN. No wrap is required: the FIFO handles address wrap internally.
- abort clears all state, counters and buffer entries, drops any in-flight datum, and raises no done. fifo_rd_rewind is not issued on abort.
- Async reset mid-operation: identical effect to abort, immediate.

## Timing
- Reset values:
  - busy, done, fifo_rd_en, fifo_rd_rewind, m_valid, m_last, m_frame_last = 0.
  - m_data = 0.
- start accepted at cycle 0; first fifo_rd_en at cycle 1 if FIFO not empty; first m_valid at cycle 2.
- With m_ready held high and the FIFO non-empty, throughput is 1 sample/cycle.
- Inter-pass cost: one rewind cycle plus one read-issue cycle. Pass k's last read is at cycle t, rewind at t+1, next pass's first read at t+2.
- Back-pressure: m_data, m_last and m_frame_last stay stable while m_valid && !m_ready. The buffer never overflows; occupancy is ≤2 at all times.
- fifo_empty stalls READ without advancing counters; reads resume the cycle fifo_empty falls.
- done asserts the cycle after the handshake of the m_frame_last sample; busy falls in the same cycle.
- start in the done cycle is ignored; start the following cycle is accepted.
- abort has priority over start and over all state transitions.

## Test plan
- FRAME_LEN=8, FIFO preloaded 0..7, num_passes=1, m_ready=1 -> m_data 0..7 on cycles 2..9; m_last and m_frame_last only on 7; done at cycle 10.
- Same preload, num_passes=3 -> sequence 0..7 three times with m_last on every 7 and m_frame_last only on the third. Exactly two fifo_rd_rewind pulses, each one cycle long.
- Random m_ready (50%), 3 passes -> no loss or duplication; data stable while stalled; occupancy never exceeds 2.
- FIFO fed at 1 word every 3 cycles, num_passes=1 -> fifo_rd_en never asserted with fifo_empty=1; all 8 words delivered in order.
- abort asserted mid-pass 2 with m_ready=0 -> next cycle busy=0, m_valid=0, no done. A new start then replays from word 0.
- num_passes=0 -> behaves exactly as 1 pass.
